// File: rtl/axis_bf_cmult_mc_if.sv
// Complex-sample AXI stream: separate real and imaginary data lanes sharing one handshake and tlast.
interface axis_bf_cmult_mc_if #(
    parameter int DW = 512
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] real_tdata;
    logic [DW-1:0] imag_tdata;
    logic          tlast;

    modport master (output tvalid, input tready, output real_tdata, output imag_tdata, output tlast);
    modport slave  (input tvalid, output tready, input real_tdata, input imag_tdata, input tlast);
endinterface

// File: rtl/axis_bf_cmult_mc.sv
// Multi-channel complex weight stage: y = x * w per channel, rounded half-up and saturated,
// with double-buffered weights that only swap between frames.
module axis_bf_cmult_mc #(
    parameter int NUM_CH      = 4,
    parameter int SAMPLES     = 8,
    parameter int SAMPLE_W    = 16,
    parameter int WEIGHT_W    = 8,
    parameter int WEIGHT_FRAC = 7,
    parameter int DW          = NUM_CH * SAMPLES * SAMPLE_W,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    axis_bf_cmult_mc_if.slave          s_axis,
    axis_bf_cmult_mc_if.master         m_axis,
    output logic [DW/8-1:0]            m_axis_tkeep,
    input  logic                       w_wr,
    input  logic [CH_W-1:0]            w_ch,
    input  logic signed [WEIGHT_W-1:0] w_re,
    input  logic signed [WEIGHT_W-1:0] w_im,
    input  logic                       w_commit,
    output logic                       w_pending,
    input  logic                       ovf_clear,
    output logic                       ovf_sticky
);
    localparam int NS = NUM_CH * SAMPLES;
    localparam int PW = SAMPLE_W + WEIGHT_W;
    localparam int SW = PW + 1;
    localparam logic signed [WEIGHT_W-1:0] W_ONE = WEIGHT_W'((1 << WEIGHT_FRAC) - 1);
    localparam logic signed [SW-1:0] MAX_V = SW'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [SW-1:0] MIN_V = SW'(-(1 << (SAMPLE_W - 1)));
    localparam logic signed [SW-1:0] HALF  = SW'(1 << (WEIGHT_FRAC - 1));

    function automatic logic signed [SW-1:0] round_half_up(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] t;
        t = v + HALF;
        return t >>> WEIGHT_FRAC;
    endfunction

    function automatic logic is_clip(input logic signed [SW-1:0] v);
        return (v > MAX_V) || (v < MIN_V);
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [SW-1:0] v);
        logic signed [SAMPLE_W-1:0] r;
        if (v > MAX_V)      r = MAX_V[SAMPLE_W-1:0];
        else if (v < MIN_V) r = MIN_V[SAMPLE_W-1:0];
        else                r = v[SAMPLE_W-1:0];
        return r;
    endfunction

    logic en, accept, last_acc, swap, pend_req;
    logic frame_open_q, frame_open_d, pending_q, pending_d, ovf_q;
    logic signed [WEIGHT_W-1:0] sh_re_q [NUM_CH];
    logic signed [WEIGHT_W-1:0] sh_im_q [NUM_CH];
    logic signed [WEIGHT_W-1:0] sh_re_d [NUM_CH];
    logic signed [WEIGHT_W-1:0] sh_im_d [NUM_CH];
    logic signed [WEIGHT_W-1:0] act_re_q [NUM_CH];
    logic signed [WEIGHT_W-1:0] act_im_q [NUM_CH];
    logic signed [WEIGHT_W-1:0] act_re_d [NUM_CH];
    logic signed [WEIGHT_W-1:0] act_im_d [NUM_CH];
    logic signed [WEIGHT_W-1:0] cap_re [NUM_CH];
    logic signed [WEIGHT_W-1:0] cap_im [NUM_CH];

    logic vld_p0, vld_p1, vld_p2, tlast_p0, tlast_p1, tlast_p2;
    logic signed [SAMPLE_W-1:0] xr_p0 [NS];
    logic signed [SAMPLE_W-1:0] xi_p0 [NS];
    logic signed [WEIGHT_W-1:0] wr_p0 [NUM_CH];
    logic signed [WEIGHT_W-1:0] wi_p0 [NUM_CH];
    logic signed [PW-1:0] prr_p1 [NS];
    logic signed [PW-1:0] pii_p1 [NS];
    logic signed [PW-1:0] pri_p1 [NS];
    logic signed [PW-1:0] pir_p1 [NS];
    logic signed [SW-1:0] rnd_re [NS];
    logic signed [SW-1:0] rnd_im [NS];
    logic [DW-1:0] re_d, im_d, re_p2, im_p2;
    logic clip_d;

    assign en            = !vld_p2 || m_axis.tready;
    assign accept        = s_axis.tvalid && en;
    assign last_acc      = accept && s_axis.tlast;
    assign s_axis.tready = en;

    // A beat opening a frame in the swap cycle must see the new weights, otherwise the frame splits.
    always_comb begin
        sh_re_d = sh_re_q;
        sh_im_d = sh_im_q;
        if (w_wr && (int'(w_ch) < NUM_CH)) begin
            sh_re_d[w_ch] = w_re;
            sh_im_d[w_ch] = w_im;
        end
        pend_req  = pending_q || w_commit;
        swap      = pend_req && (!frame_open_q || last_acc);
        pending_d = pend_req && !swap;
        act_re_d  = act_re_q;
        act_im_d  = act_im_q;
        if (swap) begin
            act_re_d = sh_re_d;
            act_im_d = sh_im_d;
        end
        cap_re = act_re_d;
        cap_im = act_im_d;
        if (frame_open_q) begin
            cap_re = act_re_q;
            cap_im = act_im_q;
        end
        frame_open_d = accept ? !s_axis.tlast : frame_open_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_open_q <= 1'b0;
            pending_q    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                sh_re_q[c]  <= W_ONE;
                sh_im_q[c]  <= '0;
                act_re_q[c] <= W_ONE;
                act_im_q[c] <= '0;
            end
        end else begin
            frame_open_q <= frame_open_d;
            pending_q    <= pending_d;
            sh_re_q      <= sh_re_d;
            sh_im_q      <= sh_im_d;
            act_re_q     <= act_re_d;
            act_im_q     <= act_im_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            tlast_p0 <= 1'b0;
            tlast_p1 <= 1'b0;
            tlast_p2 <= 1'b0;
            re_p2    <= '0;
            im_p2    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (en) begin
                vld_p0   <= s_axis.tvalid;
                vld_p1   <= vld_p0;
                vld_p2   <= vld_p1;
                tlast_p0 <= s_axis.tvalid && s_axis.tlast;
                tlast_p1 <= tlast_p0;
                tlast_p2 <= tlast_p1;
                re_p2    <= re_d;
                im_p2    <= im_d;
            end
            if (en && vld_p1 && clip_d) ovf_q <= 1'b1;
            else if (ovf_clear)         ovf_q <= 1'b0;
        end
    end

    // S1: capture samples with the weights in force for this beat; S2: the four partial products
    always_ff @(posedge clock) begin
        if (en) begin
            for (int n = 0; n < NS; n++) begin
                xr_p0[n] <= s_axis.real_tdata[n*SAMPLE_W +: SAMPLE_W];
                xi_p0[n] <= s_axis.imag_tdata[n*SAMPLE_W +: SAMPLE_W];
            end
            for (int c = 0; c < NUM_CH; c++) begin
                wr_p0[c] <= cap_re[c];
                wi_p0[c] <= cap_im[c];
            end
            for (int n = 0; n < NS; n++) begin
                prr_p1[n] <= PW'(xr_p0[n]) * PW'(wr_p0[n / SAMPLES]);
                pii_p1[n] <= PW'(xi_p0[n]) * PW'(wi_p0[n / SAMPLES]);
                pri_p1[n] <= PW'(xr_p0[n]) * PW'(wi_p0[n / SAMPLES]);
                pir_p1[n] <= PW'(xi_p0[n]) * PW'(wr_p0[n / SAMPLES]);
            end
        end
    end

    // S3: combine, round and saturate into the output register
    always_comb begin
        re_d   = '0;
        im_d   = '0;
        clip_d = 1'b0;
        rnd_re = '{default: '0};
        rnd_im = '{default: '0};
        for (int n = 0; n < NS; n++) begin
            rnd_re[n] = round_half_up(SW'(prr_p1[n]) - SW'(pii_p1[n]));
            rnd_im[n] = round_half_up(SW'(pri_p1[n]) + SW'(pir_p1[n]));
            clip_d    = clip_d | is_clip(rnd_re[n]) | is_clip(rnd_im[n]);
            re_d[n*SAMPLE_W +: SAMPLE_W] = saturate(rnd_re[n]);
            im_d[n*SAMPLE_W +: SAMPLE_W] = saturate(rnd_im[n]);
        end
    end

    assign m_axis.tvalid     = vld_p2;
    assign m_axis.real_tdata = re_p2;
    assign m_axis.imag_tdata = im_p2;
    assign m_axis.tlast      = tlast_p2;
    assign m_axis_tkeep      = {(DW/8){vld_p2}};
    assign w_pending         = pending_q;
    assign ovf_sticky        = ovf_q;
endmodule
